// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a valid/ready
// handshake, synchronous flush (clr) and bubble zeroing (out_data = RST_VAL
// whenever out_valid = 0).
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> 2-entry skid buffer (main + skid), with
//                                    in_ready driven straight from a flop.
//                       undefined -> single register, in_ready is
//                                    combinational (~out_valid | out_ready).
module pipe_stage_reg #(
  parameter int unsigned          WIDTH   = 32,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              clr,        // synchronous flush, active-high
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy
);

`ifdef PIPE_STAGE_SKID_EN

  // The state encoding equals the number of beats held.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               accept;
  logic               issue;

  assign accept    = in_valid & in_ready_q;
  assign issue     = (state_q != S_EMPTY) & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;

  // Occupancy decoded from the state; the unused encoding reads as empty.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      S_ONE:   occupancy = 2'd1;
      S_FULL:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and datapath: main always holds the head beat, skid the
  // second one; a register that drops its beat reloads RST_VAL so the
  // output bus shows RST_VAL during bubbles.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clr) begin
      // A beat accepted in this cycle is discarded as well.
      state_d = S_EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (accept && !issue) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (accept && issue) begin
            main_d  = in_data;
          end else if (issue) begin
            state_d = S_EMPTY;
            main_d  = RST_VAL;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no accept can coincide with the issue.
          if (issue) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = RST_VAL;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = RST_VAL;
          skid_d  = RST_VAL;
        end
      endcase
    end
    // Registered ready: only the FULL state blocks the producer.
    in_ready_d = (state_d != S_FULL);
  end

  // State, payload and ready registers; reset drops every held beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      main_q     <= RST_VAL;
      skid_q     <= RST_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;

  // The stage can take a new beat when empty or when its beat leaves now.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occupancy = {1'b0, valid_q};

  // Next-state: flush wins, otherwise load (or bubble) when ready, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (in_ready) begin
      valid_d = in_valid;
      data_d  = in_valid ? in_data : RST_VAL;
    end
  end

  // Single stage register; reset drops the held beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (WIDTH=32, RST_VAL=0).
// Skid-specific expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int WIDTH = 32;

  logic              clk;
  logic              reset;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  pipe_stage_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] occ);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".out_data"},  out_data, d);
    check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    // 1: reset asserted with a beat offered
    reset     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b0;
    #3;
    check_out("rst_async", 1'b0, 32'h0, 2'd0);
    check("rst_async.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    check_out("rst_held", 1'b0, 32'h0, 2'd0);
    check("rst_held.in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check_out("idle", 1'b0, 32'h0, 2'd0);

    // 2: back-to-back streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    check_out("stream0", 1'b1, 32'h11, 2'd1);
    in_data = 32'h22;
    tick();
    check_out("stream1", 1'b1, 32'h22, 2'd1);
    in_data = 32'h33;
    tick();
    check_out("stream2", 1'b1, 32'h33, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("stream_end", 1'b0, 32'h0, 2'd0);

    // 3: stall with 0xAA held, 0xBB offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    tick();
    check_out("stall_load", 1'b1, 32'hAA, 2'd1);
    in_data = 32'hBB;
    check("stall.in_ready_pre", {31'd0, in_ready}, SKID ? 32'd1 : 32'd0);
    tick();
    check_out("stall_hold", 1'b1, 32'hAA, SKID ? 2'd2 : 2'd1);
    check("stall.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_out("stall_hold2", 1'b1, 32'hAA, SKID ? 2'd2 : 2'd1);
    // Release: base accepts 0xBB now; skid drains 0xAA and shifts 0xBB up.
    out_ready = 1'b1;
    tick();
    check_out("release_bb", 1'b1, 32'hBB, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("release_empty", 1'b0, 32'h0, 2'd0);

    // 4: flush while holding 0xAA, 0x55 offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    tick();
    check_out("flush_load", 1'b1, 32'hAA, 2'd1);
    clr     = 1'b1;
    in_data = 32'h55;
    tick();
    check_out("flush", 1'b0, 32'h0, 2'd0);
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("flush_after", 1'b0, 32'h0, 2'd0);
    tick();
    check_out("flush_after2", 1'b0, 32'h0, 2'd0);

    // 5: asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    tick();
    in_data = 32'hBB;
    tick();
    check_out("areset_pre", 1'b1, 32'hAA, SKID ? 2'd2 : 2'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_out("areset_now", 1'b0, 32'h0, 2'd0);
    check("areset_now.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    #2;
    reset = 1'b1;
    tick();
    check_out("areset_release", 1'b0, 32'h0, 2'd0);

    // 6: single-cycle bubble between 0x01 and 0x02
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h01;
    tick();
    check_out("bubble_01", 1'b1, 32'h01, 2'd1);
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    tick();
    check_out("bubble_gap", 1'b0, 32'h0, 2'd0);
    in_valid = 1'b1;
    in_data  = 32'h02;
    tick();
    check_out("bubble_02", 1'b1, 32'h02, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("bubble_end", 1'b0, 32'h0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
